// File: rtl/inst_queue.sv
// inst_queue: dual-issue instruction queue between fetch and Decoder.
//
// Holds up to DEPTH fetched instructions in program order. Fetch pushes 0-2
// instructions per cycle. The two oldest entries go to Decoder as inst0/inst1.
// Both are popped together when Decoder is not stalled. A writeback flush
// empties the queue.
//
// Optional build macro: IQ_BYPASS_EN. When it is defined and the queue is
// empty, the fetch slots drive the f1 outputs in the same cycle. If Decoder
// accepts them, they are never written into the queue.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   flush_iq_i                      discard all entries (beats stall/enq/deq)
//   stall_decoder_inst0/1_i         Decoder slot stalls; either one blocks the pop
//   fetch_inst0/1_{valid,pc,inst}_i fetch slots; slot1 is younger and needs slot0
//   iq_ready_o                      room for two more entries (registered count only)
//   inst0/1_f1_{valid,pc,inst}_o    oldest and second-oldest entries to Decoder
//   iq_count_o                      current occupancy
module inst_queue #(
    parameter int  DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_iq_i,
    input  logic             stall_decoder_inst0_i,
    input  logic             stall_decoder_inst1_i,
    input  logic             fetch_inst0_valid_i,
    input  logic [63:0]      fetch_inst0_pc_i,
    input  logic [31:0]      fetch_inst0_inst_i,
    input  logic             fetch_inst1_valid_i,
    input  logic [63:0]      fetch_inst1_pc_i,
    input  logic [31:0]      fetch_inst1_inst_i,
    output logic             iq_ready_o,
    output logic             inst0_f1_valid_o,
    output logic [63:0]      inst0_f1_pc_o,
    output logic [31:0]      inst0_f1_inst_o,
    output logic             inst1_f1_valid_o,
    output logic [63:0]      inst1_f1_pc_o,
    output logic [31:0]      inst1_f1_inst_o,
    output logic [PTR_W:0]   iq_count_o
);

    localparam int CNT_W = PTR_W + 1;

    logic [63:0]      mem_pc_q   [DEPTH];
    logic [63:0]      mem_pc_d   [DEPTH];
    logic [31:0]      mem_inst_q [DEPTH];
    logic [31:0]      mem_inst_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             ready;
    logic             accept;
    logic             st_v0, st_v1;
    logic             byp_take;
    logic             enq0, enq1;
    logic [1:0]       enq_n, deq_n;
    logic [PTR_W-1:0] rd_ptr_p1, wr_ptr_p1;

    always_comb begin
        rd_ptr_p1 = rd_ptr_q + PTR_W'(1);
        wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

        // Ready looks only at the registered count. A pop in the same cycle
        // does not free room early.
        ready  = (count_q <= CNT_W'(DEPTH - 2));
        accept = !stall_decoder_inst0_i && !stall_decoder_inst1_i && !flush_iq_i;

        // Valids of the stored entries. Reset and flush mask them at once.
        st_v0 = (count_q != '0)         && !flush_iq_i && !rst;
        st_v1 = (count_q >= CNT_W'(2))  && !flush_iq_i && !rst;

        inst0_f1_valid_o = st_v0;
        inst0_f1_pc_o    = st_v0 ? mem_pc_q[rd_ptr_q]    : 64'd0;
        inst0_f1_inst_o  = st_v0 ? mem_inst_q[rd_ptr_q]  : 32'd0;
        inst1_f1_valid_o = st_v1;
        inst1_f1_pc_o    = st_v1 ? mem_pc_q[rd_ptr_p1]   : 64'd0;
        inst1_f1_inst_o  = st_v1 ? mem_inst_q[rd_ptr_p1] : 32'd0;
        byp_take         = 1'b0;

`ifdef IQ_BYPASS_EN
        if ((count_q == '0) && !flush_iq_i && !rst) begin
            inst0_f1_valid_o = fetch_inst0_valid_i;
            inst0_f1_pc_o    = fetch_inst0_valid_i ? fetch_inst0_pc_i   : 64'd0;
            inst0_f1_inst_o  = fetch_inst0_valid_i ? fetch_inst0_inst_i : 32'd0;
            inst1_f1_valid_o = fetch_inst0_valid_i && fetch_inst1_valid_i;
            inst1_f1_pc_o    = inst1_f1_valid_o ? fetch_inst1_pc_i   : 64'd0;
            inst1_f1_inst_o  = inst1_f1_valid_o ? fetch_inst1_inst_i : 32'd0;
            // When Decoder takes the bypassed slots, they are never stored.
            byp_take         = accept && fetch_inst0_valid_i;
        end
`endif

        enq0  = fetch_inst0_valid_i && ready && !flush_iq_i && !rst && !byp_take;
        enq1  = enq0 && fetch_inst1_valid_i;
        enq_n = {1'b0, enq0} + {1'b0, enq1};

        // Only stored entries are popped. A bypassed pair never enters the
        // count, so it must not leave it either.
        deq_n = accept ? ({1'b0, st_v0} + {1'b0, st_v1}) : 2'd0;

        mem_pc_d   = mem_pc_q;
        mem_inst_d = mem_inst_q;
        if (enq0) begin
            mem_pc_d[wr_ptr_q]   = fetch_inst0_pc_i;
            mem_inst_d[wr_ptr_q] = fetch_inst0_inst_i;
        end
        if (enq1) begin
            mem_pc_d[wr_ptr_p1]   = fetch_inst1_pc_i;
            mem_inst_d[wr_ptr_p1] = fetch_inst1_inst_i;
        end

        rd_ptr_d = rd_ptr_q + PTR_W'(deq_n);
        wr_ptr_d = wr_ptr_q + PTR_W'(enq_n);
        count_d  = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);

        if (flush_iq_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end

        iq_ready_o = ready;
        iq_count_o = rst ? '0 : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // The storage array has no reset. Entries are only read when count says
    // they hold data.
    always_ff @(posedge clk) begin
        mem_pc_q   <= mem_pc_d;
        mem_inst_q <= mem_inst_d;
    end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_iq_i;
    logic        stall_decoder_inst0_i;
    logic        stall_decoder_inst1_i;
    logic        fetch_inst0_valid_i;
    logic [63:0] fetch_inst0_pc_i;
    logic [31:0] fetch_inst0_inst_i;
    logic        fetch_inst1_valid_i;
    logic [63:0] fetch_inst1_pc_i;
    logic [31:0] fetch_inst1_inst_i;
    logic        iq_ready_o;
    logic        inst0_f1_valid_o;
    logic [63:0] inst0_f1_pc_o;
    logic [31:0] inst0_f1_inst_o;
    logic        inst1_f1_valid_o;
    logic [63:0] inst1_f1_pc_o;
    logic [31:0] inst1_f1_inst_o;
    logic [3:0]  iq_count_o;

    int errors = 0;
    int checks = 0;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .flush_iq_i            (flush_iq_i),
        .stall_decoder_inst0_i (stall_decoder_inst0_i),
        .stall_decoder_inst1_i (stall_decoder_inst1_i),
        .fetch_inst0_valid_i   (fetch_inst0_valid_i),
        .fetch_inst0_pc_i      (fetch_inst0_pc_i),
        .fetch_inst0_inst_i    (fetch_inst0_inst_i),
        .fetch_inst1_valid_i   (fetch_inst1_valid_i),
        .fetch_inst1_pc_i      (fetch_inst1_pc_i),
        .fetch_inst1_inst_i    (fetch_inst1_inst_i),
        .iq_ready_o            (iq_ready_o),
        .inst0_f1_valid_o      (inst0_f1_valid_o),
        .inst0_f1_pc_o         (inst0_f1_pc_o),
        .inst0_f1_inst_o       (inst0_f1_inst_o),
        .inst1_f1_valid_o      (inst1_f1_valid_o),
        .inst1_f1_pc_o         (inst1_f1_pc_o),
        .inst1_f1_inst_o       (inst1_f1_inst_o),
        .iq_count_o            (iq_count_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_pair(input logic v0, input logic [63:0] pc0,
                              input logic v1, input logic [63:0] pc1);
        fetch_inst0_valid_i = v0;
        fetch_inst0_pc_i    = pc0;
        fetch_inst0_inst_i  = pc0[31:0] ^ 32'h0000_0013;
        fetch_inst1_valid_i = v1;
        fetch_inst1_pc_i    = pc1;
        fetch_inst1_inst_i  = pc1[31:0] ^ 32'h0000_0013;
    endtask

    logic [63:0] exp_pc;
    logic [63:0] next_pc;
    int          seen;

    initial begin
        rst = 1'b1;
        flush_iq_i = 1'b0;
        stall_decoder_inst0_i = 1'b0;
        stall_decoder_inst1_i = 1'b0;
        drive_pair(1'b1, 64'hAAAA, 1'b1, 64'hBBBB);

        // Reset held two cycles with fetch valid.
        tick();
        tick();
        chk("rst_v0", inst0_f1_valid_o, 1'b0);
        chk("rst_v1", inst1_f1_valid_o, 1'b0);
        chk("rst_count", iq_count_o, 4'd0);
        rst = 1'b0;
        drive_pair(1'b0, 64'h0, 1'b0, 64'h0);
        #1;
        chk("post_rst_ready", iq_ready_o, 1'b1);
        chk("post_rst_v0", inst0_f1_valid_o, 1'b0);
        tick();
        chk("post_rst_count", iq_count_o, 4'd0);

        // Dual enqueue, then dequeue with no stalls.
        drive_pair(1'b1, 64'h1000, 1'b1, 64'h1004);
        tick();
        drive_pair(1'b0, 64'h0, 1'b0, 64'h0);
        chk("dual_v0", inst0_f1_valid_o, 1'b1);
        chk("dual_pc0", inst0_f1_pc_o, 64'h1000);
        chk("dual_inst0", inst0_f1_inst_o, 32'h0000_1013);
        chk("dual_v1", inst1_f1_valid_o, 1'b1);
        chk("dual_pc1", inst1_f1_pc_o, 64'h1004);
        chk("dual_count", iq_count_o, 4'd2);
        tick();
        chk("dual_drain_count", iq_count_o, 4'd0);
        chk("dual_drain_v0", inst0_f1_valid_o, 1'b0);
        chk("dual_drain_pc0", inst0_f1_pc_o, 64'h0);

        // Slot1 stall blocks the pop; fill the queue with four pairs.
        stall_decoder_inst1_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_pair(1'b1, 64'h1000 + 64'(8 * k), 1'b1, 64'h1004 + 64'(8 * k));
            tick();
            if (k == 2) begin
                chk("fill_count6", iq_count_o, 4'd6);
                chk("fill_ready6", iq_ready_o, 1'b1);
            end
        end
        chk("full_count", iq_count_o, 4'd8);
        chk("full_ready", iq_ready_o, 1'b0);
        drive_pair(1'b1, 64'h1020, 1'b1, 64'h1024);
        tick();
        chk("full_hold_count", iq_count_o, 4'd8);
        chk("full_hold_pc0", inst0_f1_pc_o, 64'h1000);
        chk("full_hold_pc1", inst1_f1_pc_o, 64'h1004);
        drive_pair(1'b0, 64'h0, 1'b0, 64'h0);
        stall_decoder_inst1_i = 1'b0;
        tick();
        chk("drain1_count", iq_count_o, 4'd6);
        chk("drain1_pc0", inst0_f1_pc_o, 64'h1008);
        chk("drain1_pc1", inst1_f1_pc_o, 64'h100C);
        tick();
        chk("drain2_pc0", inst0_f1_pc_o, 64'h1010);
        tick();
        tick();
        chk("drain_empty", iq_count_o, 4'd0);

        // Flush with count 5 and an enqueue in the same cycle.
        stall_decoder_inst1_i = 1'b1;
        drive_pair(1'b1, 64'h3000, 1'b0, 64'h0);
        tick();
        drive_pair(1'b1, 64'h3004, 1'b1, 64'h3008);
        tick();
        drive_pair(1'b1, 64'h300C, 1'b1, 64'h3010);
        tick();
        chk("pre_flush_count", iq_count_o, 4'd5);
        chk("pre_flush_pc0", inst0_f1_pc_o, 64'h3000);
        drive_pair(1'b1, 64'h3014, 1'b1, 64'h3018);
        flush_iq_i = 1'b1;
        #1;
        chk("flush_v0", inst0_f1_valid_o, 1'b0);
        chk("flush_v1", inst1_f1_valid_o, 1'b0);
        chk("flush_pc0", inst0_f1_pc_o, 64'h0);
        tick();
        flush_iq_i = 1'b0;
        drive_pair(1'b0, 64'h0, 1'b0, 64'h0);
        chk("post_flush_count", iq_count_o, 4'd0);
        chk("post_flush_v0", inst0_f1_valid_o, 1'b0);
        drive_pair(1'b1, 64'h5000, 1'b0, 64'h0);
        tick();
        drive_pair(1'b0, 64'h0, 1'b0, 64'h0);
        chk("after_flush_pc0", inst0_f1_pc_o, 64'h5000);
        chk("after_flush_count", iq_count_o, 4'd1);

        // Odd count 7 must already refuse a pair.
        for (int k = 0; k < 3; k++) begin
            drive_pair(1'b1, 64'h5004 + 64'(8 * k), 1'b1, 64'h5008 + 64'(8 * k));
            tick();
        end
        drive_pair(1'b0, 64'h0, 1'b0, 64'h0);
        chk("count7", iq_count_o, 4'd7);
        chk("count7_ready", iq_ready_o, 1'b0);
        flush_iq_i = 1'b1;
        tick();
        flush_iq_i = 1'b0;
        stall_decoder_inst1_i = 1'b0;
        chk("flush2_count", iq_count_o, 4'd0);

        // Wrap-around: one single, then pairs across index 7 -> 0 with continuous pop.
        exp_pc  = 64'h4000;
        next_pc = 64'h4000;
        seen    = 0;
        drive_pair(1'b1, next_pc, 1'b0, 64'h0);
        next_pc = next_pc + 64'd4;
        tick();
        for (int i = 0; i < 10; i++) begin
            if (inst0_f1_valid_o) begin
                chk("wrap_pc0", inst0_f1_pc_o, exp_pc);
                exp_pc = exp_pc + 64'd4;
                seen++;
            end
            if (inst1_f1_valid_o) begin
                chk("wrap_pc1", inst1_f1_pc_o, exp_pc);
                exp_pc = exp_pc + 64'd4;
                seen++;
            end
            if (i < 6) begin
                drive_pair(1'b1, next_pc, 1'b1, next_pc + 64'd4);
                next_pc = next_pc + 64'd8;
            end else begin
                drive_pair(1'b0, 64'h0, 1'b0, 64'h0);
            end
            tick();
        end
        chk("wrap_seen", 64'(seen), 64'd13);
        chk("wrap_last_pc", exp_pc, 64'h4034);
        chk("wrap_end_count", iq_count_o, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
